cfs_md_packer: RTL and testbench

- Downstream stage of the aligner. Consumes the aligner's MD TX stream and packs the valid bytes of each transfer into contiguous full-width words.
- Output is a simple valid/ready word stream (DMA/FIFO writer side).
- Provides an explicit flush to emit a trailing partial word, and a saturating counter of illegal transfers that were dropped.
- Single clock domain.

---
 rtl/cfs_md_pkg.sv | 30 +++
 rtl/cfs_md_packer.sv | 101 ++++++++++
 tb/tb_cfs_md_packer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfs_md_pkg.sv
// Shared MD stream types and helpers for the aligner and packer.
// Width helpers, the transfer item and the legality rule.
package cfs_md_pkg;

    localparam int MD_MAX_DW = 128;
    localparam int MD_MAX_OW = 4;
    localparam int MD_MAX_SW = 5;
    localparam int CNT_DROP_WIDTH = 8;

    typedef struct packed {
        logic [MD_MAX_DW-1:0] data;
        logic [MD_MAX_OW-1:0] offset;
        logic [MD_MAX_SW-1:0] size;
    } md_item_t;

    function automatic int md_off_w(input int dw);
        return (dw <= 8) ? 1 : $clog2(dw / 8);
    endfunction

    function automatic int md_size_w(input int dw);
        return $clog2(dw / 8) + 1;
    endfunction

    function automatic bit md_is_legal(input int unsigned offset,
                                       input int unsigned size,
                                       input int unsigned bytes);
        return (size != 0) && (offset + size <= bytes);
    endfunction

endpackage

// File: rtl/cfs_md_packer.sv
// Packs valid bytes of MD transfers into contiguous full-width words.
// Supports an explicit flush for the trailing partial word.
module cfs_md_packer
    import cfs_md_pkg::*;
#(
    parameter int ALGN_DATA_WIDTH = 32,
    localparam int BYTES = ALGN_DATA_WIDTH / 8,
    localparam int ALGN_OFFSET_WIDTH = md_off_w(ALGN_DATA_WIDTH),
    localparam int ALGN_SIZE_WIDTH = md_size_w(ALGN_DATA_WIDTH),
    localparam int FILL_WIDTH = $clog2(BYTES) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         md_rx_valid,
    input  logic [ALGN_DATA_WIDTH-1:0]   md_rx_data,
    input  logic [ALGN_OFFSET_WIDTH-1:0] md_rx_offset,
    input  logic [ALGN_SIZE_WIDTH-1:0]   md_rx_size,
    output logic                         md_rx_ready,
    output logic                         md_rx_err,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [ALGN_DATA_WIDTH-1:0]   out_data,
    output logic [ALGN_SIZE_WIDTH-1:0]   out_bytes,
    input  logic                         out_ready,
    output logic [CNT_DROP_WIDTH-1:0]    cnt_drop,
    output logic                         busy
);

    localparam logic [FILL_WIDTH-1:0] L_BYTES = FILL_WIDTH'(BYTES);

    logic [2*ALGN_DATA_WIDTH-1:0] r_buf;
    logic [2*ALGN_DATA_WIDTH-1:0] w_buf_nxt;
    logic [FILL_WIDTH-1:0]        r_fill;
    logic [FILL_WIDTH-1:0]        w_fill_nxt;
    logic                         r_flush_pend;
    logic                         w_pend_nxt;
    logic [CNT_DROP_WIDTH-1:0]    r_cnt_drop;
    logic [ALGN_SIZE_WIDTH:0]     w_end;
    logic [ALGN_DATA_WIDTH-1:0]   w_src;
    logic                         w_legal;
    logic                         w_acc;
    logic                         w_pop;
    int                           w_f;
    int                           w_s;

    always_comb begin
        w_f = int'(r_fill);
        w_s = int'(md_rx_size);
        // Sum is one bit wider than size so offset+size never wraps.
        w_end = {1'b0, md_rx_size} + (ALGN_SIZE_WIDTH+1)'(md_rx_offset);
        w_legal = (md_rx_size != '0) &&
                  (w_end <= (ALGN_SIZE_WIDTH+1)'(BYTES));
        md_rx_ready = md_rx_valid && (r_fill < L_BYTES) && !r_flush_pend;
        md_rx_err = md_rx_ready && !w_legal;
        w_acc = md_rx_ready && w_legal;
        out_valid = (r_fill >= L_BYTES) || (r_flush_pend && r_fill != '0);
        out_bytes = (r_fill >= L_BYTES) ? ALGN_SIZE_WIDTH'(BYTES)
                                        : ALGN_SIZE_WIDTH'(r_fill);
        w_pop = out_valid && out_ready;
        w_src = md_rx_data >> {md_rx_offset, 3'b000};
        out_data = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (i < w_f) out_data[i*8 +: 8] = r_buf[i*8 +: 8];
        end
        w_buf_nxt = r_buf;
        w_fill_nxt = r_fill;
        if (w_pop) begin
            w_buf_nxt = r_buf >> {out_bytes, 3'b000};
            w_fill_nxt = r_fill - FILL_WIDTH'(out_bytes);
        end else if (w_acc) begin
            for (int i = 0; i < 2*BYTES; i++) begin
                if (i >= w_f && i < w_f + w_s)
                    w_buf_nxt[i*8 +: 8] = w_src[(i - w_f)*8 +: 8];
            end
            w_fill_nxt = r_fill + FILL_WIDTH'(md_rx_size);
        end
        w_pend_nxt = r_flush_pend;
        if (w_pop && w_fill_nxt == '0) w_pend_nxt = 1'b0;
        // Bytes accepted this cycle count toward a same-cycle flush.
        if (flush && w_fill_nxt != '0) w_pend_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf <= '0;
            r_fill <= '0;
            r_flush_pend <= 1'b0;
            r_cnt_drop <= '0;
        end else begin
            r_buf <= w_buf_nxt;
            r_fill <= w_fill_nxt;
            r_flush_pend <= w_pend_nxt;
            if (md_rx_err && r_cnt_drop != '1)
                r_cnt_drop <= r_cnt_drop + 1'b1;
        end
    end

    assign cnt_drop = r_cnt_drop;
    assign busy = (r_fill != '0) || r_flush_pend;

endmodule

// File: tb/tb_cfs_md_packer.sv
// Scoreboard bench for cfs_md_packer at 32-bit width.
// Directed transfers push expected words; a monitor pops on handshake.
module tb_cfs_md_packer;
    import cfs_md_pkg::*;

    logic        clk;
    logic        reset;
    logic        md_rx_valid;
    logic [31:0] md_rx_data;
    logic [1:0]  md_rx_offset;
    logic [2:0]  md_rx_size;
    logic        md_rx_ready;
    logic        md_rx_err;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_ready;
    logic [7:0]  cnt_drop;
    logic        busy;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  b;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;

    cfs_md_packer #(.ALGN_DATA_WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .md_rx_valid(md_rx_valid),
        .md_rx_data(md_rx_data),
        .md_rx_offset(md_rx_offset),
        .md_rx_size(md_rx_size),
        .md_rx_ready(md_rx_ready),
        .md_rx_err(md_rx_err),
        .flush(flush),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_bytes(out_bytes),
        .out_ready(out_ready),
        .cnt_drop(cnt_drop),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word: got %0h/%0d want none",
                         out_data, out_bytes);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_data !== e.d || out_bytes !== e.b) begin
                    n_err++;
                    $display("FAIL word: got %0h/%0d want %0h/%0d",
                             out_data, out_bytes, e.d, e.b);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input int off, input int sz,
                        input logic exp_err);
        int k;
        md_rx_data = d;
        md_rx_offset = 2'(off);
        md_rx_size = 3'(sz);
        md_rx_valid = 1'b1;
        #1;
        k = 0;
        while (!md_rx_ready && k < 100) begin
            step();
            k++;
        end
        if (k == 100) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got ready=0 want ready=1");
        end else begin
            chk("rx_err", 32'(md_rx_err), 32'(exp_err));
        end
        step();
        md_rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || q.size() != 0) && k < 100) begin
            step();
            k++;
        end
        if (k == 100) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: got busy=%0d q=%0d want 0/0",
                     busy, q.size());
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        md_rx_valid = 1'b0;
        md_rx_data = '0;
        md_rx_offset = '0;
        md_rx_size = '0;
        flush = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_bytes", 32'(out_bytes), 0);
        chk("rst_data", out_data, 0);
        chk("rst_ready", 32'(md_rx_ready), 0);
        chk("rst_err", 32'(md_rx_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(cnt_drop), 0);

        // four single-byte transfers at rising offsets
        q.push_back('{32'hDDCCBBAA, 3'd4});
        send(32'h000000AA, 0, 1, 1'b0);
        send(32'h0000BB00, 1, 1, 1'b0);
        send(32'h00CC0000, 2, 1, 1'b0);
        send(32'hDD000000, 3, 1, 1'b0);
        chk("word_next_cycle", 32'(out_valid), 1);
        wait_idle();

        // overflow into second word, then flush remainder
        q.push_back('{32'h44221100, 3'd4});
        q.push_back('{32'h00776655, 3'd3});
        send(32'h33221100, 0, 3, 1'b0);
        send(32'h77665544, 0, 4, 1'b0);
        pulse_flush();
        wait_idle();
        chk("flush_busy", 32'(busy), 0);

        // illegal transfers and saturation
        send(32'h12345678, 3, 2, 1'b1);
        send(32'h12345678, 0, 0, 1'b1);
        step();
        chk("drop2", 32'(cnt_drop), 2);
        chk("drop_busy", 32'(busy), 0);
        for (int i = 0; i < 258; i++) begin
            int o;
            int s;
            o = (i % 2 == 0) ? 1 : 2;
            s = (i % 2 == 0) ? 4 : 3;
            send(32'hFFFFFFFF, o, s, 1'b1 ^ 1'(md_is_legal(o, s, 4)));
        end
        step();
        chk("drop_sat", 32'(cnt_drop), 255);

        // output stall holds data and blocks input
        out_ready = 1'b0;
        q.push_back('{32'h87654321, 3'd4});
        send(32'h87654321, 0, 4, 1'b0);
        md_rx_valid = 1'b1;
        md_rx_data = 32'h000000AB;
        md_rx_offset = 2'd0;
        md_rx_size = 3'd1;
        for (int i = 0; i < 10; i++) begin
            chk("stall_ready", 32'(md_rx_ready), 0);
            chk("stall_data", out_data, 32'h87654321);
            step();
        end
        md_rx_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("after_pop_valid", 32'(out_valid), 0);
        chk("after_pop_qlen", 32'(q.size()), 0);
        md_rx_valid = 1'b1;
        #1;
        chk("reopen_ready", 32'(md_rx_ready), 1);
        md_rx_valid = 1'b0;
        step();

        // flush with six bytes held
        q.push_back('{32'h44332211, 3'd4});
        q.push_back('{32'h00006655, 3'd2});
        send(32'h00332211, 0, 3, 1'b0);
        send(32'h00665544, 0, 3, 1'b0);
        pulse_flush();
        chk("flush6_block", 32'(busy), 1);
        wait_idle();
        md_rx_valid = 1'b1;
        #1;
        chk("flush6_reopen", 32'(md_rx_ready), 1);
        md_rx_valid = 1'b0;

        // flush while empty is ignored
        pulse_flush();
        chk("flush0_busy", 32'(busy), 0);
        step();
        step();
        chk("flush0_valid", 32'(out_valid), 0);

        // flush coincident with an accept includes that byte
        q.push_back('{32'h000000EE, 3'd1});
        flush = 1'b1;
        send(32'h0000EE00, 1, 1, 1'b0);
        flush = 1'b0;
        wait_idle();

        // reset mid-accumulation
        send(32'h0000BBAA, 0, 2, 1'b0);
        chk("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_valid", 32'(out_valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_drop", 32'(cnt_drop), 0);
        q.push_back('{32'h04030201, 3'd4});
        send(32'h00000201, 0, 2, 1'b0);
        send(32'h04030000, 2, 2, 1'b0);
        wait_idle();

        step();
        chk("queue_empty", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
